// File: rtl/demux4_1_pipe_if.sv
// demux4_1_pipe_if: bus bundle for the 1-to-4 registered distributor.
// The master side is the producer plus the four consumers; the slave
// side is the distributor itself.
interface demux4_1_pipe_if #(
    parameter int WIDTH = 64
);
    // producer side
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;

    // consumer side
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    modport master (
        output in_data,
        output in_sel,
        output in_valid,
        input  in_ready,
        input  out_data0,
        input  out_data1,
        input  out_data2,
        input  out_data3,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_sel,
        input  in_valid,
        output in_ready,
        output out_data0,
        output out_data1,
        output out_data2,
        output out_data3,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/demux4_1_pipe.sv
// demux4_1_pipe: registered 1-to-4 distributor. Each input word is steered
// by in_sel into one of four single-entry output channels, each with its
// own valid/ready handshake, so a stalled consumer only blocks words aimed
// at its own channel.
//
// Optional build macro: DEMUX4_STATS_EN adds a stat_count port with one
// 16-bit wrapping accept counter per channel (channel i at [16i+15:16i]).
//
// Per-channel state table:
//   state | meaning
//   EMPTY | no word held, out_valid[i] = 0
//   FULL  | word held in out_data_i, out_valid[i] = 1, data stable
module demux4_1_pipe #(
    parameter int WIDTH = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    demux4_1_pipe_if.slave  bus
`ifdef DEMUX4_STATS_EN
    ,
    output logic [63:0]     stat_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];

    logic             sel_ready;
    logic             accept;
    logic [3:0]       load;

    // Ready looks only at the selected channel; an accept loads exactly that channel.
    always_comb begin
        sel_ready = (state_q[bus.in_sel] == EMPTY) || bus.out_ready[bus.in_sel];
        accept    = bus.in_valid && sel_ready;
        load      = 4'b0000;
        if (accept) begin
            load[bus.in_sel] = 1'b1;
        end
    end

    // Next-state for every channel; drain and refill in one cycle stays FULL.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                EMPTY: begin
                    if (load[i]) begin
                        state_d[i] = FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready[i] && !load[i]) begin
                        state_d[i] = EMPTY;
                    end
                end
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Channel data registers; only a load changes them, so a held word is stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= bus.in_data;
                end
            end
        end
    end

    // Outputs come straight from registers; in_data never reaches them combinationally.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.out_valid[i] = (state_q[i] == FULL);
        end
    end

    assign bus.in_ready  = sel_ready;
    assign bus.out_data0 = data_q[0];
    assign bus.out_data1 = data_q[1];
    assign bus.out_data2 = data_q[2];
    assign bus.out_data3 = data_q[3];

`ifdef DEMUX4_STATS_EN
    logic [15:0] cnt_q [4];

    // Per-channel accept counters, free-running wrap at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    cnt_q[i] <= cnt_q[i] + 16'h0001;
                end
            end
        end
    end

    assign stat_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux4_1_pipe.sv
// tb_demux4_1_pipe: self-checking bench for demux4_1_pipe. A behavioural
// channel model plus per-channel scoreboard queues provide all expected
// values; a vector table covers routing and backpressure, hand sequences
// cover reset, drain-and-refill and counter wrap, and a random phase
// stresses ordering and stability.
module tb_demux4_1_pipe;

    logic clk;
    logic reset_n;

    demux4_1_pipe_if #(.WIDTH(64)) bus ();

`ifdef DEMUX4_STATS_EN
    logic [63:0] stat_count;
`endif

    demux4_1_pipe #(.WIDTH(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DEMUX4_STATS_EN
        ,
        .stat_count (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model
    logic [3:0]  m_valid;
    logic [63:0] m_data [4];
    logic [15:0] m_stat [4];
    int          n_deliv [4];
    logic [63:0] q0[$], q1[$], q2[$], q3[$];

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [63:0] d;
        logic [3:0]  r;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_data(input int i);
        case (i)
            0:       return bus.out_data0;
            1:       return bus.out_data1;
            2:       return bus.out_data2;
            default: return bus.out_data3;
        endcase
    endfunction

    task automatic sb_push(input int ch, input logic [63:0] d);
        case (ch)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            2:       q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic sb_pop(input int ch, output logic ok, output logic [63:0] d);
        ok = 1'b0;
        d  = '0;
        case (ch)
            0: if (q0.size() > 0) begin ok = 1'b1; d = q0.pop_front(); end
            1: if (q1.size() > 0) begin ok = 1'b1; d = q1.pop_front(); end
            2: if (q2.size() > 0) begin ok = 1'b1; d = q2.pop_front(); end
            default: if (q3.size() > 0) begin ok = 1'b1; d = q3.pop_front(); end
        endcase
    endtask

    task automatic model_clear();
        m_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0;
            m_stat[i] = '0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    // One cycle: drive at negedge, observe 1ns later, then advance the model
    // to what the next posedge should produce.
    task automatic step(input logic v, input logic [1:0] s, input logic [63:0] d,
                        input logic [3:0] r, output logic obs_rdy, output logic [3:0] obs_ov);
        logic        exp_rdy;
        logic        ok;
        logic [63:0] exp_d;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        obs_rdy = bus.in_ready;
        obs_ov  = bus.out_valid;
        check("out_valid", {60'd0, bus.out_valid}, {60'd0, m_valid});
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i]) check("out_data_held", get_data(i), m_data[i]);
        end
        exp_rdy = !m_valid[s] || r[s];
        check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
`ifdef DEMUX4_STATS_EN
        check("stat_count", stat_count, {m_stat[3], m_stat[2], m_stat[1], m_stat[0]});
`endif
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && r[i]) begin
                sb_pop(i, ok, exp_d);
                check("sb_nonempty", {63'd0, ok}, 64'd1);
                if (ok) check("deliver_order", get_data(i), exp_d);
                n_deliv[i]++;
                m_valid[i] = 1'b0;
            end
        end
        if (v && exp_rdy) begin
            m_valid[s] = 1'b1;
            m_data[s]  = d;
            sb_push(int'(s), d);
            m_stat[s]  = m_stat[s] + 16'h0001;
        end
    endtask

    initial begin
        logic       rdy;
        logic [3:0] ov;
        int         n0;

        for (int i = 0; i < 4; i++) n_deliv[i] = 0;
        model_clear();

        // reset held low with in_valid high
        reset_n       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 64'hDEAD;
        bus.out_ready = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", {60'd0, bus.out_valid}, 64'd0);
        check("rst_data0", bus.out_data0, 64'd0);
        check("rst_data1", bus.out_data1, 64'd0);
        check("rst_data2", bus.out_data2, 64'd0);
        check("rst_data3", bus.out_data3, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;

        // routing then backpressure vectors
        tbl[0]  = '{1'b1, 2'd0, 64'hA0, 4'b1111, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 2'd1, 64'hA1, 4'b1111, 1'b1, 4'b0001};
        tbl[2]  = '{1'b1, 2'd2, 64'hA2, 4'b1111, 1'b1, 4'b0010};
        tbl[3]  = '{1'b1, 2'd3, 64'hA3, 4'b1111, 1'b1, 4'b0100};
        tbl[4]  = '{1'b0, 2'd0, 64'h00, 4'b1111, 1'b1, 4'b1000};
        tbl[5]  = '{1'b0, 2'd0, 64'h00, 4'b1111, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 2'd1, 64'h11, 4'b1101, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 2'd1, 64'h99, 4'b1101, 1'b0, 4'b0010};
        tbl[8]  = '{1'b1, 2'd3, 64'h33, 4'b1101, 1'b1, 4'b0010};
        tbl[9]  = '{1'b0, 2'd1, 64'h00, 4'b1101, 1'b0, 4'b1010};
        tbl[10] = '{1'b0, 2'd0, 64'h00, 4'b1111, 1'b1, 4'b0010};
        tbl[11] = '{1'b0, 2'd0, 64'h00, 4'b1111, 1'b1, 4'b0000};

        for (int k = 0; k < 12; k++) begin
            step(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].r, rdy, ov);
            check($sformatf("tbl%0d_in_ready", k), {63'd0, rdy}, {63'd0, tbl[k].exp_rdy});
            check($sformatf("tbl%0d_out_valid", k), {60'd0, ov}, {60'd0, tbl[k].exp_ov});
            if (k == 9) begin
                check("bp_data1_held", bus.out_data1, 64'h11);
                check("bp_data3", bus.out_data3, 64'h33);
            end
        end

        // drain and refill on channel 0
        step(1'b1, 2'd0, 64'h5, 4'b0000, rdy, ov);
        step(1'b0, 2'd0, 64'h0, 4'b0000, rdy, ov);
        check("dr_first_word", bus.out_data0, 64'h5);
        n0 = n_deliv[0];
        step(1'b1, 2'd0, 64'h6, 4'b0001, rdy, ov);
        check("dr_in_ready", {63'd0, rdy}, 64'd1);
        step(1'b0, 2'd0, 64'h0, 4'b0000, rdy, ov);
        check("dr_valid0", {63'd0, bus.out_valid[0]}, 64'd1);
        check("dr_refill_word", bus.out_data0, 64'h6);
        check("dr_deliveries", 64'(n_deliv[0] - n0), 64'd1);
        step(1'b0, 2'd0, 64'h0, 4'b0001, rdy, ov);
        step(1'b0, 2'd0, 64'h0, 4'b0000, rdy, ov);

        // async reset while channel 2 is FULL
        step(1'b1, 2'd2, 64'hC2, 4'b0000, rdy, ov);
        step(1'b0, 2'd2, 64'h0, 4'b0000, rdy, ov);
        check("ar_pre_valid2", {63'd0, bus.out_valid[2]}, 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_valid_cleared", {60'd0, bus.out_valid}, 64'd0);
        check("ar_data2_cleared", bus.out_data2, 64'd0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;

        // random stress
        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)), rdy, ov);
        end
        step(1'b0, 2'd0, 64'h0, 4'b1111, rdy, ov);
        step(1'b0, 2'd0, 64'h0, 4'b1111, rdy, ov);
        check("sb_drained", 64'(q0.size() + q1.size() + q2.size() + q3.size()), 64'd0);

`ifdef DEMUX4_STATS_EN
        // counter wrap on channel 2
        reset_n = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 32'hFFFE; k++) begin
            step(1'b1, 2'd2, 64'(k), 4'b1111, rdy, ov);
        end
        step(1'b0, 2'd0, 64'h0, 4'b1111, rdy, ov);
        check("stat_preload", {48'd0, stat_count[47:32]}, 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'd2, 64'(k), 4'b1111, rdy, ov);
        end
        step(1'b0, 2'd0, 64'h0, 4'b1111, rdy, ov);
        check("stat_wrap_ch2", {48'd0, stat_count[47:32]}, 64'h0001);
        check("stat_other", {16'd0, stat_count[63:48], stat_count[31:0]}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux4_1_pipe.md
Name: demux4_1_pipe

Overview:
- Registered 1-to-4 distributor: one input stream with a 2-bit select `{sel1, sel0}` steers each word into one of four output channels.
- It is the inverse of the 4:1 select path and sits between the writeback/forwarding source and four consumer stages in the pipelined CPU.
- Each channel holds one registered entry with a valid/ready handshake, so one backpressured consumer stalls only words destined for it.

Parameters:
- WIDTH, 64, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  2  destination channel; bit1 = sel1, bit0 = sel0; 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  the selected channel can accept this cycle.
- out_data0..out_data3  output  WIDTH each  channel data registers.
- out_valid  output  4  per-channel valid, bit i = channel i.
- out_ready  input  4  per-channel consumer ready, bit i = channel i.
- stat_count  output  4x16 (64)  accepted-word counters, channel i at bits [16i+15:16i]; present only with DEMUX4_STATS_EN.

Behaviour:
- Reset (reset_n low, asynchronous assert; deassert sampled at clk):
  - out_valid = 4'b0000; out_data0..3 = 0.
  - stat_count = 0 when compiled in.
  - Reset mid-transfer discards all held words; no output is produced for them.
- Per-channel state machine, channel i:
  - EMPTY: out_valid[i] = 0.
  - FULL: out_valid[i] = 1, out_data_i stable.
  - EMPTY→FULL on accept targeting i.
  - FULL→EMPTY on out_ready[i] with no accept targeting i.
  - FULL→FULL with new data on out_ready[i] plus accept targeting i (drain and refill in the same cycle).
  - FULL, no out_ready[i]: hold; data must not change.
- in_ready (combinational) = !out_valid[s] || out_ready[s], where s = in_sel. It depends only on the selected channel.
- Accept = in_valid && in_ready. On accept, out_data_s <= in_data and out_valid[s] <= 1 at the next clk edge.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle per channel when its consumer holds out_ready high.
- Ordering: words to the same channel are delivered in acceptance order. No ordering guarantee across channels.
- in_valid = 0: no channel loads; in_ready still reflects the selected channel.
- Non-selected channels drain independently in the same cycle as an accept to another channel.
- No combinational path from in_data to outputs.
- No path from out_ready[j] to in_ready unless j == in_sel.
- No word is ever dropped or duplicated.

Optional Feature:
- Macro DEMUX4_STATS_EN.
- Defined:
  - stat_count port exists.
  - Counter i increments by 1 on each accept targeting channel i.
  - 16-bit counters wrap 0xFFFF→0x0000 with no flag.
  - Counters reset to 0 on reset_n low.
- Undefined: no stat_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 → out_valid=0000, out_data0..3=0, in_ready=1. Assert reset_n=0 asynchronously while ch2 is FULL → out_valid[2] clears before the next clk edge.
- Routing: out_ready=1111; send 0xA0 sel=00, 0xA1 sel=01, 0xA2 sel=10, 0xA3 sel=11 on consecutive cycles → each appears one cycle later on the matching out_data with a one-hot out_valid pulse.
- Backpressure: out_ready[1]=0; send 0x11 sel=01 → ch1 FULL; in_ready=0 while sel=01. Switch to sel=11 → in_ready=1, 0x33 delivered on ch3 while out_data1 stays 0x11.
- Drain and refill: ch0 FULL with 0x5; same cycle out_ready[0]=1, in_valid=1, sel=00, data 0x6 → next cycle out_valid[0]=1, out_data0=0x6, consumer saw 0x5 exactly once.
- Random stress: 10k cycles of random in_valid/in_sel/out_ready → scoreboard shows per-channel in-order delivery with no loss or duplication, and out_data held stable while valid && !ready.
- DEMUX4_STATS_EN: preload ch2 count to 0xFFFE via 0xFFFE accepts; 3 more accepts to ch2 → stat_count ch2 = 0x0001; other channels unchanged.
